// File: rtl/bcd_updown_counter_nd_pkg.sv
// Shared constants for the N-digit BCD up/down counter: digit width and
// active-low 7-segment codes (bit 6 = seg a ... bit 0 = seg g).
package bcd_updown_counter_nd_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Single BCD digit to active-low 7-segment decoder; non-BCD codes go blank.
module bcd_to_7seg
    import bcd_updown_counter_nd_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [6:0]       o_seg
);

    // Pure lookup; anything above 9 lights nothing.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_updown_counter_nd.sv
// N-digit BCD up/down counter with tick divider, rate select, synchronous
// load, wrap pulse and per-digit 7-segment outputs.
module bcd_updown_counter_nd
    import bcd_updown_counter_nd_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 50_000_000,
    parameter int LZ_BLANK = 0
)
(
    input  logic                      CLOCK_50Mhz,
    input  logic                      RESET,
    input  logic                      EN,
    input  logic                      UP,
    input  logic [1:0]                SPEED,
    input  logic                      LOAD,
    input  logic [BCD_W*DIGITS-1:0]   LOAD_VAL,
    output logic [BCD_W*DIGITS-1:0]   COUNT,
    output logic [7*DIGITS-1:0]       HEX,
    output logic                      TICK,
    output logic                      WRAP
);

    localparam int DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0]        r_div;
    logic [BCD_W*DIGITS-1:0] r_count;
    logic                    r_tick;
    logic                    r_wrap;

    logic [DIV_W-1:0]        w_last;
    logic                    w_term;
    logic [BCD_W*DIGITS-1:0] w_step_val;
    logic [BCD_W*DIGITS-1:0] w_load_val;
    logic                    w_wrap;
    logic [DIGITS-1:0]       w_blank;
    logic [7*DIGITS-1:0]     w_seg;

    // Terminal divider value for the selected rate; >= so a rate increase never stalls.
    assign w_last = DIV_W'((TICK_DIV >> SPEED) - 1);
    assign w_term = (r_div >= w_last);

    // Ripple carry/borrow across digits; carry surviving past the top digit is a wrap.
    always_comb begin
        logic [BCD_W-1:0] w_dig;
        logic             w_cy;
        w_step_val = r_count;
        w_cy       = 1'b1;
        w_dig      = '0;
        for (int d = 0; d < DIGITS; d++) begin
            w_dig = r_count[d*BCD_W +: BCD_W];
            if (w_cy) begin
                if (UP) begin
                    if (w_dig == 4'd9) begin
                        w_step_val[d*BCD_W +: BCD_W] = 4'd0;
                    end else begin
                        w_step_val[d*BCD_W +: BCD_W] = w_dig + 4'd1;
                        w_cy = 1'b0;
                    end
                end else begin
                    if (w_dig == 4'd0) begin
                        w_step_val[d*BCD_W +: BCD_W] = 4'd9;
                    end else begin
                        w_step_val[d*BCD_W +: BCD_W] = w_dig - 4'd1;
                        w_cy = 1'b0;
                    end
                end
            end
        end
        w_wrap = w_cy;
    end

    // Load value with any non-BCD digit forced to 0.
    always_comb begin
        w_load_val = LOAD_VAL;
        for (int d = 0; d < DIGITS; d++) begin
            if (LOAD_VAL[d*BCD_W +: BCD_W] > 4'd9) begin
                w_load_val[d*BCD_W +: BCD_W] = 4'd0;
            end
        end
    end

    // Divider, tick pulse, count and wrap; RESET beats LOAD beats a step.
    always_ff @(posedge CLOCK_50Mhz) begin
        if (RESET) begin
            r_div   <= '0;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (LOAD) begin
            r_div   <= '0;
            r_count <= w_load_val;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            if (w_term) begin
                r_div  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_div  <= r_div + DIV_W'(1);
                r_tick <= 1'b0;
            end
            if (r_tick && EN) begin
                r_count <= w_step_val;
                r_wrap  <= w_wrap;
            end else begin
                r_wrap  <= 1'b0;
            end
        end
    end

    // Field d blanks when it and every higher digit are zero; field 0 always shows.
    always_comb begin
        logic w_hi_zero;
        w_hi_zero = 1'b1;
        w_blank   = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            w_hi_zero  = w_hi_zero & (r_count[d*BCD_W +: BCD_W] == 4'd0);
            w_blank[d] = (LZ_BLANK != 0) && (d != 0) && w_hi_zero;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_to_7seg u_seg (
            .i_bcd (r_count[g*BCD_W +: BCD_W]),
            .o_seg (w_seg[g*7 +: 7])
        );
        assign HEX[g*7 +: 7] = w_blank[g] ? SEG_BLANK : w_seg[g*7 +: 7];
    end

    assign COUNT = r_count;
    assign TICK  = r_tick;
    assign WRAP  = r_wrap;

endmodule

// File: tb/tb_bcd_updown_counter_nd.sv
// Scoreboard bench for bcd_updown_counter_nd: two instances (LZ_BLANK 0/1),
// decimal reference model pushes expectations, popped after each edge.
module tb_bcd_updown_counter_nd;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [1:0]  speed;
    logic [7:0]  load_val;
    logic [7:0]  count_a, count_b;
    logic [13:0] hex_a, hex_b;
    logic        tick_a, tick_b, wrap_a, wrap_b;

    always #5 clk = ~clk;

    bcd_updown_counter_nd #(.DIGITS(2), .TICK_DIV(8), .LZ_BLANK(0)) dut_a (
        .CLOCK_50Mhz (clk),
        .RESET       (rst),
        .EN          (en),
        .UP          (up),
        .SPEED       (speed),
        .LOAD        (load),
        .LOAD_VAL    (load_val),
        .COUNT       (count_a),
        .HEX         (hex_a),
        .TICK        (tick_a),
        .WRAP        (wrap_a)
    );

    bcd_updown_counter_nd #(.DIGITS(2), .TICK_DIV(8), .LZ_BLANK(1)) dut_b (
        .CLOCK_50Mhz (clk),
        .RESET       (rst),
        .EN          (en),
        .UP          (up),
        .SPEED       (speed),
        .LOAD        (load),
        .LOAD_VAL    (load_val),
        .COUNT       (count_b),
        .HEX         (hex_b),
        .TICK        (tick_b),
        .WRAP        (wrap_b)
    );

    typedef struct {
        logic [7:0]  count;
        logic        tick;
        logic        wrap;
        logic [13:0] hex;
        logic [13:0] hex_lz;
    } exp_t;

    exp_t       sb_q[$];
    int         m_div   = 0;
    int         m_count = 0;
    logic       m_tick  = 1'b0;
    logic       m_wrap  = 1'b0;
    int         errors  = 0;
    int         checks  = 0;
    logic [6:0] seg_tab [10];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd_digit(input logic [3:0] d);
        return (d > 4'd9) ? 0 : int'(d);
    endfunction

    // Advance the decimal model one edge, push its outputs, clock, then compare.
    task automatic run_cycle();
        exp_t e;
        exp_t o;
        int   t;
        int   tens;
        int   ones;
        logic old_tick;
        old_tick = m_tick;
        if (rst) begin
            m_div = 0; m_count = 0; m_tick = 1'b0; m_wrap = 1'b0;
        end else if (load) begin
            m_count = bcd_digit(load_val[7:4]) * 10 + bcd_digit(load_val[3:0]);
            m_div = 0; m_tick = 1'b0; m_wrap = 1'b0;
        end else begin
            t = 8 >> speed;
            if (m_div >= t - 1) begin
                m_div = 0; m_tick = 1'b1;
            end else begin
                m_div = m_div + 1; m_tick = 1'b0;
            end
            if (old_tick && en) begin
                if (up) begin
                    m_wrap  = (m_count == 99);
                    m_count = (m_count + 1) % 100;
                end else begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count + 99) % 100;
                end
            end else begin
                m_wrap = 1'b0;
            end
        end
        tens     = m_count / 10;
        ones     = m_count % 10;
        e.count  = {4'(tens), 4'(ones)};
        e.tick   = m_tick;
        e.wrap   = m_wrap;
        e.hex    = {seg_tab[tens], seg_tab[ones]};
        e.hex_lz = (tens == 0) ? {7'b1111111, seg_tab[ones]} : e.hex;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check_val("count", 32'(count_a), 32'(o.count));
        check_val("tick", 32'(tick_a), 32'(o.tick));
        check_val("wrap", 32'(wrap_a), 32'(o.wrap));
        check_val("hex", 32'(hex_a), 32'(o.hex));
        check_val("count_lz", 32'(count_b), 32'(o.count));
        check_val("hex_lz", 32'(hex_b), 32'(o.hex_lz));
    endtask

    initial begin
        logic   found;
        logic [7:0] hold_vals [5];
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;
        hold_vals[0] = 8'h99; hold_vals[1] = 8'h00; hold_vals[2] = 8'hA5;
        hold_vals[3] = 8'h3C; hold_vals[4] = 8'h12;

        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; speed = 2'd0; load_val = 8'h00;
        #1;
        repeat (2) run_cycle();
        check_val("reset_count", 32'(count_a), 32'h00);
        check_val("reset_hex", 32'(hex_a), 32'(14'b0000001_0000001));
        check_val("reset_hex_lz", 32'(hex_b), 32'(14'b1111111_0000001));

        // Free-running up count: ten steps in 81 edges.
        rst = 1'b0; en = 1'b1; up = 1'b1;
        repeat (81) run_cycle();
        check_val("count_after_81", 32'(count_a), 32'h10);
        check_val("hex0_at_10", 32'(hex_a[6:0]), 32'(7'b0000001));

        // 98 -> 99 -> 00 with wrap on the last step.
        load = 1'b1; load_val = 8'h98; run_cycle(); load = 1'b0;
        repeat (17) run_cycle();
        check_val("up_wrap_count", 32'(count_a), 32'h00);
        check_val("up_wrap_pulse", 32'(wrap_a), 32'd1);

        // Down: 00 -> 99 wraps, 99 -> 98 does not.
        up = 1'b0;
        repeat (8) run_cycle();
        check_val("down_wrap_count", 32'(count_a), 32'h99);
        check_val("down_wrap_pulse", 32'(wrap_a), 32'd1);
        repeat (8) run_cycle();
        check_val("down_98_count", 32'(count_a), 32'h98);
        check_val("down_98_wrap", 32'(wrap_a), 32'd0);

        // Rate changes, including a jump to T=1 with the divider at 5.
        up = 1'b1; speed = 2'd3;
        repeat (6) run_cycle();
        speed = 2'd0;
        repeat (20) run_cycle();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_div == 5) begin
                found = 1'b1;
                break;
            end
            run_cycle();
        end
        check_val("wait_div5", 32'(found), 32'd1);
        speed = 2'd3; run_cycle();
        check_val("tick_after_speedup", 32'(tick_a), 32'd1);
        speed = 2'd0;

        // LOAD while a step is pending: step dropped, F coerced to 0.
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_tick) begin
                found = 1'b1;
                break;
            end
            run_cycle();
        end
        check_val("wait_tick", 32'(found), 32'd1);
        load = 1'b1; load_val = 8'h4F; run_cycle(); load = 1'b0;
        check_val("load_4F_count", 32'(count_a), 32'h40);
        check_val("load_4F_wrap", 32'(wrap_a), 32'd0);
        repeat (8) run_cycle();
        check_val("tick_8_after_load", 32'(tick_a), 32'd1);

        // LOAD held: count tracks LOAD_VAL, never wraps.
        load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_val = hold_vals[i];
            run_cycle();
        end
        load = 1'b0;

        // Leading-zero blanking.
        rst = 1'b1; run_cycle(); rst = 1'b0;
        load = 1'b1; load_val = 8'h07; run_cycle();
        check_val("lz_07", 32'(hex_b), 32'(14'b1111111_0001111));
        load_val = 8'h00; run_cycle();
        check_val("lz_00", 32'(hex_b), 32'(14'b1111111_0000001));
        load_val = 8'h55; run_cycle(); load = 1'b0;
        repeat (12) run_cycle();
        rst = 1'b1; run_cycle();
        check_val("reset_mid_count", 32'(count_a), 32'h00);
        rst = 1'b0;

        // Random mix of enable, direction, rate, loads and the odd reset.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) speed = 2'($urandom_range(0, 3));
            load     = ($urandom_range(0, 24) == 0);
            load_val = 8'($urandom);
            rst      = ($urandom_range(0, 149) == 0);
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
